// File: rtl/cci_mpf_csrs_pkg.sv
// Shared MPF CSR definitions: event index map, widths, event vector and
// read-request payload types.
package cci_mpf_csrs_pkg;

    localparam int unsigned MPF_CSR_NUM_EVENTS     = 12;
    localparam int unsigned MPF_CSR_IDX_LAST_VADDR = 12;
    localparam int unsigned MPF_CSR_IDX_WIDTH      = 4;
    localparam int unsigned MPF_CSR_TID_WIDTH      = 9;
    localparam int unsigned MPF_CSR_DATA_WIDTH     = 64;
    localparam int unsigned CCI_CLADDR_WIDTH       = 42;

    typedef enum logic [MPF_CSR_IDX_WIDTH-1:0] {
        MPF_CSR_EV_VTP_4KB_HIT      = 4'd0,
        MPF_CSR_EV_VTP_4KB_MISS     = 4'd1,
        MPF_CSR_EV_VTP_2MB_HIT      = 4'd2,
        MPF_CSR_EV_VTP_2MB_MISS     = 4'd3,
        MPF_CSR_EV_PT_WALK_BUSY     = 4'd4,
        MPF_CSR_EV_FAILED_XLATE     = 4'd5,
        MPF_CSR_EV_VC_MAP_CHANGED   = 4'd6,
        MPF_CSR_EV_WRO_RR           = 4'd7,
        MPF_CSR_EV_WRO_RW           = 4'd8,
        MPF_CSR_EV_WRO_WR           = 4'd9,
        MPF_CSR_EV_WRO_WW           = 4'd10,
        MPF_CSR_EV_PWRITE           = 4'd11,
        MPF_CSR_EV_LAST_VADDR       = 4'd12,
        MPF_CSR_EV_RSVD13           = 4'd13,
        MPF_CSR_EV_RSVD14           = 4'd14,
        MPF_CSR_EV_RSVD15           = 4'd15
    } t_mpf_csr_event_idx;

    typedef logic [MPF_CSR_NUM_EVENTS-1:0] t_mpf_csr_events;

    typedef struct packed {
        logic                         valid;
        logic [MPF_CSR_IDX_WIDTH-1:0] idx;
        logic [MPF_CSR_TID_WIDTH-1:0] tid;
    } t_mpf_csr_rd_req;

endpackage

// File: rtl/mpf_csr_event_counter.sv
// Single wrapping event counter.
//   clk, reset : clock and synchronous active-high reset
//   inc        : add one this cycle
//   clr        : zero this cycle (wins over inc)
//   count      : registered counter value
module mpf_csr_event_counter #(
    parameter int unsigned CNTR_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  clr,
    output logic [CNTR_WIDTH-1:0] count
);

    logic [CNTR_WIDTH-1:0] count_q;
    logic [CNTR_WIDTH-1:0] count_d;

    // Clear wins over a same-cycle increment; overflow wraps silently.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CNTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mpf_csr_event_counters.sv
// MPF CSR event counters: accumulates shim event strobes and serves
// fixed-latency MMIO reads (response two cycles after request).
//   clk, reset          : clock, synchronous active-high reset
//   events              : per-cycle event strobes (index map in package)
//   pt_walk_last_vaddr  : last page-walk line address, read at index 12
//   rd_req_*            : read request (valid / register index / tid)
//   clr_valid, clr_mask : masked counter clear
//   rd_rsp_*            : read response (valid pulse / 64b data / echoed tid)
module mpf_csr_event_counters
    import cci_mpf_csrs_pkg::*;
#(
    parameter int unsigned CNTR_WIDTH = 48,
    parameter int unsigned NUM_EVENTS = MPF_CSR_NUM_EVENTS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_EVENTS-1:0]         events,
    input  logic [CCI_CLADDR_WIDTH-1:0]   pt_walk_last_vaddr,
    input  logic                          rd_req_valid,
    input  logic [MPF_CSR_IDX_WIDTH-1:0]  rd_req_idx,
    input  logic [MPF_CSR_TID_WIDTH-1:0]  rd_req_tid,
    input  logic                          clr_valid,
    input  logic [NUM_EVENTS-1:0]         clr_mask,
    output logic                          rd_rsp_valid,
    output logic [MPF_CSR_DATA_WIDTH-1:0] rd_rsp_data,
    output logic [MPF_CSR_TID_WIDTH-1:0]  rd_rsp_tid
);

    logic [NUM_EVENTS-1:0]         ev_e1_q;
    logic [NUM_EVENTS-1:0]         ev_e2_q;
    logic [NUM_EVENTS-1:0]         clr_q;
    logic [CCI_CLADDR_WIDTH-1:0]   vaddr_e1_q;
    logic [CCI_CLADDR_WIDTH-1:0]   vaddr_e2_q;
    logic [CCI_CLADDR_WIDTH-1:0]   last_vaddr_q;
    t_mpf_csr_rd_req               rd_s1_q;
    logic                          rsp_valid_q;
    logic [MPF_CSR_DATA_WIDTH-1:0] rsp_data_q;
    logic [MPF_CSR_DATA_WIDTH-1:0] rsp_data_d;
    logic [MPF_CSR_TID_WIDTH-1:0]  rsp_tid_q;
    logic [CNTR_WIDTH-1:0]         cnt [NUM_EVENTS];

    // The read mux samples storage one cycle after the request, so every
    // storage input is delayed one extra stage. A read then observes the
    // state as of its request cycle: pre-clear on a same-cycle clear, and
    // events only from two or more cycles earlier.
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_e1_q      <= '0;
            ev_e2_q      <= '0;
            clr_q        <= '0;
            vaddr_e1_q   <= '0;
            vaddr_e2_q   <= '0;
            last_vaddr_q <= '0;
            rd_s1_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_tid_q    <= '0;
        end else begin
            ev_e1_q      <= events;
            ev_e2_q      <= ev_e1_q;
            clr_q        <= clr_valid ? clr_mask : '0;
            vaddr_e1_q   <= pt_walk_last_vaddr;
            vaddr_e2_q   <= vaddr_e1_q;
            last_vaddr_q <= vaddr_e2_q;
            rd_s1_q      <= '{valid: rd_req_valid, idx: rd_req_idx, tid: rd_req_tid};
            rsp_valid_q  <= rd_s1_q.valid;
            rsp_data_q   <= rsp_data_d;
            rsp_tid_q    <= rd_s1_q.tid;
        end
    end

    // One counter per event; clear is fanned out from the registered mask.
    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cntr
        mpf_csr_event_counter #(
            .CNTR_WIDTH(CNTR_WIDTH)
        ) u_cntr (
            .clk   (clk),
            .reset (reset),
            .inc   (ev_e2_q[g]),
            .clr   (clr_q[g]),
            .count (cnt[g])
        );
    end

    // 16:1 read mux; reserved indices return zero.
    always_comb begin
        rsp_data_d = '0;
        if (rd_s1_q.idx < MPF_CSR_IDX_WIDTH'(NUM_EVENTS)) begin
            rsp_data_d = MPF_CSR_DATA_WIDTH'(cnt[rd_s1_q.idx]);
        end else if (rd_s1_q.idx == MPF_CSR_IDX_WIDTH'(MPF_CSR_IDX_LAST_VADDR)) begin
            rsp_data_d = MPF_CSR_DATA_WIDTH'(last_vaddr_q);
        end
    end

    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_data  = rsp_data_q;
    assign rd_rsp_tid   = rsp_tid_q;

endmodule

// File: tb/tb_mpf_csr_event_counters.sv
module tb_mpf_csr_event_counters;
    import cci_mpf_csrs_pkg::*;

    logic                        clk;
    logic                        reset;
    logic [11:0]                 events;
    logic [CCI_CLADDR_WIDTH-1:0] pt_walk_last_vaddr;
    logic                        rd_req_valid;
    logic [3:0]                  rd_req_idx;
    logic [8:0]                  rd_req_tid;
    logic                        clr_valid;
    logic [11:0]                 clr_mask;
    logic                        rd_rsp_valid;
    logic [63:0]                 rd_rsp_data;
    logic [8:0]                  rd_rsp_tid;
    logic                        rd_rsp_valid8;
    logic [63:0]                 rd_rsp_data8;
    logic [8:0]                  rd_rsp_tid8;

    mpf_csr_event_counters #(.CNTR_WIDTH(48)) dut (
        .clk(clk), .reset(reset), .events(events),
        .pt_walk_last_vaddr(pt_walk_last_vaddr),
        .rd_req_valid(rd_req_valid), .rd_req_idx(rd_req_idx), .rd_req_tid(rd_req_tid),
        .clr_valid(clr_valid), .clr_mask(clr_mask),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_tid(rd_rsp_tid)
    );

    mpf_csr_event_counters #(.CNTR_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .events(events),
        .pt_walk_last_vaddr(pt_walk_last_vaddr),
        .rd_req_valid(rd_req_valid), .rd_req_idx(rd_req_idx), .rd_req_tid(rd_req_tid),
        .clr_valid(clr_valid), .clr_mask(clr_mask),
        .rd_rsp_valid(rd_rsp_valid8), .rd_rsp_data(rd_rsp_data8), .rd_rsp_tid(rd_rsp_tid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [8:0]  tid;
        logic [63:0] d48;
        logic [63:0] d8;
    } exp_t;

    typedef struct {
        int unsigned cyc;
        logic [8:0]  tid;
        logic [63:0] d48;
        logic [63:0] d8;
        logic        v8;
    } obs_t;

    typedef struct {
        logic [3:0]  idx;
        logic [63:0] exp;
    } vec_t;

    exp_t exp_q[$];
    obs_t obs [512];
    int   obs_n  = 0;
    int   rd_ptr = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Response monitor: records every response seen, away from the clock edge.
    always @(negedge clk) begin
        if (rd_rsp_valid === 1'b1 && obs_n < 512) begin
            obs[obs_n] = '{cyc: cyc, tid: rd_rsp_tid, d48: rd_rsp_data,
                           d8: rd_rsp_data8, v8: rd_rsp_valid8};
            obs_n = obs_n + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [8:0] tid,
                      input logic [63:0] e48, input logic [63:0] e8);
        rd_req_valid = 1'b1;
        rd_req_idx   = idx;
        rd_req_tid   = tid;
        exp_q.push_back('{cyc: cyc + 2, tid: tid, d48: e48, d8: e8});
        step();
        rd_req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        exp_t e;
        obs_t o;
        repeat (4) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_ptr >= obs_n) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s_missing: got no response expected tid %h", tag, e.tid);
            end else begin
                o = obs[rd_ptr];
                rd_ptr++;
                chk({tag, "_cycle"}, 64'(o.cyc), 64'(e.cyc));
                chk({tag, "_tid"},   64'(o.tid), 64'(e.tid));
                chk({tag, "_data"},  o.d48, e.d48);
                chk({tag, "_v8"},    64'(o.v8), 64'd1);
                chk({tag, "_data8"}, o.d8, e.d8);
            end
        end
        chk({tag, "_extra"}, 64'(obs_n - rd_ptr), 64'd0);
        rd_ptr = obs_n;
    endtask

    localparam logic [41:0] VA_A = 42'h3FF_FFFF_FFFF;
    localparam logic [41:0] VA_B = 42'h155_5555_5555;

    vec_t tbl [16];
    int   base;

    initial begin
        reset = 1'b1; events = '0; pt_walk_last_vaddr = '0;
        rd_req_valid = 1'b0; rd_req_idx = '0; rd_req_tid = '0;
        clr_valid = 1'b0; clr_mask = '0;
        repeat (3) step();
        chk("rst_valid", 64'(rd_rsp_valid), 64'd0);
        chk("rst_data",  rd_rsp_data, 64'd0);
        chk("rst_tid",   64'(rd_rsp_tid), 64'd0);
        reset = 1'b0;

        // Reset readback of all 16 indices, back to back.
        for (int i = 0; i < 16; i++) tbl[i] = '{idx: 4'(i), exp: 64'd0};
        base = obs_n;
        for (int i = 0; i < 16; i++) rd(tbl[i].idx, 9'(i * 37 + 5), tbl[i].exp, tbl[i].exp);
        drain("reset_rd");
        chk("reset_rd_count", 64'(obs_n - base), 64'd16);

        // Event 0 pulsed 5 cycles, event 4 held 100 cycles.
        events[0] = 1'b1; events[4] = 1'b1;
        repeat (5) step();
        events[0] = 1'b0;
        rd(4'd0, 9'h011, 64'd4, 64'd4);
        repeat (94) step();
        events[4] = 1'b0;
        rd(4'd4, 9'h012, 64'd99, 64'd99);
        rd(4'd4, 9'h013, 64'd100, 64'd100);
        rd(4'd0, 9'h014, 64'd5, 64'd5);
        drain("busy");

        // Clear all, then all events together for 7 cycles.
        clr_valid = 1'b1; clr_mask = 12'hFFF;
        step();
        clr_valid = 1'b0; clr_mask = '0;
        events = 12'hFFF;
        repeat (7) step();
        events = '0;
        repeat (2) step();
        for (int i = 0; i < 16; i++) tbl[i] = '{idx: 4'(i), exp: (i < 12) ? 64'd7 : 64'd0};
        for (int i = 0; i < 16; i++) rd(tbl[i].idx, 9'(9'h100 + i), tbl[i].exp, tbl[i].exp);
        drain("all7");

        // Wrap: 260 increments on event 11.
        clr_valid = 1'b1; clr_mask = 12'h800;
        step();
        clr_valid = 1'b0; clr_mask = '0;
        events[11] = 1'b1;
        repeat (260) step();
        events = '0;
        repeat (2) step();
        rd(4'd11, 9'h021, 64'd260, 64'd4);
        rd(4'd10, 9'h022, 64'd7, 64'd7);
        drain("wrap");

        // Clear with same-cycle read and event; pending E1 increment dropped.
        events[2] = 1'b1;
        step();
        events = 12'h001;
        clr_valid = 1'b1; clr_mask = 12'h005;
        rd(4'd0, 9'h031, 64'd7, 64'd7);
        clr_valid = 1'b0; clr_mask = '0; events = '0;
        rd(4'd0, 9'h032, 64'd0, 64'd0);
        rd(4'd0, 9'h033, 64'd1, 64'd1);
        rd(4'd1, 9'h034, 64'd7, 64'd7);
        rd(4'd2, 9'h035, 64'd0, 64'd0);
        drain("clr");

        // Last vaddr: zero-extended, visible two cycles after drive.
        pt_walk_last_vaddr = VA_A;
        step();
        pt_walk_last_vaddr = VA_B;
        step();
        rd(4'd12, 9'h041, 64'h0000_03FF_FFFF_FFFF, 64'h0000_03FF_FFFF_FFFF);
        rd(4'd12, 9'h042, 64'h0000_0155_5555_5555, 64'h0000_0155_5555_5555);
        drain("vaddr");

        // Reset with two reads in flight: no response may emerge.
        rd_req_valid = 1'b1; rd_req_idx = 4'd12; rd_req_tid = 9'h051;
        step();
        rd_req_tid = 9'h052; reset = 1'b1;
        step();
        rd_req_valid = 1'b0;
        step();
        chk("rst_mid_valid", 64'(rd_rsp_valid), 64'd0);
        reset = 1'b0;
        repeat (5) step();
        chk("rst_flush", 64'(obs_n - rd_ptr), 64'd0);
        rd_ptr = obs_n;
        rd(4'd11, 9'h061, 64'd0, 64'd0);
        rd(4'd1,  9'h062, 64'd0, 64'd0);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
